// File: rtl/fp_issue_ctrl.sv
// Issue/response controller sitting between a request source and a pipelined FPU.
// Tracks in-flight operations with credits and buffers results in an in-order response FIFO.
module fp_issue_ctrl #(
    parameter int NUM_OPERANDS = 3,
    parameter int WIDTH        = 64,
    parameter int TAG_WIDTH    = 4,
    parameter int DEPTH        = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  logic [NUM_OPERANDS*WIDTH-1:0]   req_operands_i,
    input  logic [TAG_WIDTH-1:0]            req_tag_i,
    output logic                            fpu_in_valid_o,
    input  logic                            fpu_in_ready_i,
    output logic [NUM_OPERANDS*WIDTH-1:0]   fpu_operands_o,
    output logic [TAG_WIDTH-1:0]            fpu_tag_o,
    output logic                            fpu_flush_o,
    input  logic [WIDTH-1:0]                fpu_result_i,
    input  logic [4:0]                      fpu_status_i,
    input  logic [TAG_WIDTH-1:0]            fpu_tag_i,
    input  logic                            fpu_out_valid_i,
    output logic                            fpu_out_ready_o,
    input  logic                            fpu_busy_i,
    output logic                            rsp_valid_o,
    input  logic                            rsp_ready_i,
    output logic [WIDTH-1:0]                rsp_result_o,
    output logic [4:0]                      rsp_status_o,
    output logic [TAG_WIDTH-1:0]            rsp_tag_o,
    input  logic                            flush_i,
    output logic                            idle_o,
    output logic [$clog2(DEPTH):0]          credits_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = WIDTH + 5 + TAG_WIDTH;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;

    logic [1:0]                    state_q, state_d;
    logic                          issueValid_q, issueValid_d;
    logic [NUM_OPERANDS*WIDTH-1:0] issueOps_q, issueOps_d;
    logic [TAG_WIDTH-1:0]          issueTag_q, issueTag_d;
    logic [CW-1:0]                 credits_q, credits_d;
    logic                          flushPulse_q, flushPulse_d;
    logic                          started_q;
    logic [AW:0]                   wrPtr_q, wrPtr_d;
    logic [AW:0]                   rdPtr_q, rdPtr_d;
    logic [EW-1:0]                 fifoMem_q [DEPTH];

    logic          runState;
    logic          issueFire;
    logic          reqAccept;
    logic          rspPush;
    logic          rspPop;
    logic          flushStart;
    logic [AW:0]   fifoCount;
    logic [EW-1:0] headEntry;

    assign runState   = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
    assign flushStart = flush_i && (state_q != ST_FLUSH);
    assign fifoCount  = wrPtr_q - rdPtr_q;
    assign headEntry  = fifoMem_q[rdPtr_q[AW-1:0]];

    // started_q keeps the request port closed while reset is held and for the first edge after it.
    assign fpu_in_valid_o = runState && issueValid_q && (credits_q < DEPTH_C);
    assign issueFire      = fpu_in_valid_o && fpu_in_ready_i;
    assign req_ready_o    = started_q && runState && (!issueValid_q || issueFire);
    assign reqAccept      = req_valid_i && req_ready_o;

    // A result is only accepted for an operation that holds a credit but has no FIFO entry yet,
    // so stray results after a reset or flush never become responses and the FIFO cannot overflow.
    assign fpu_out_ready_o = 1'b1;
    assign rspPush         = fpu_out_valid_i && runState && (credits_q > fifoCount);
    assign rsp_valid_o     = runState && (fifoCount != '0);
    assign rspPop          = rsp_valid_o && rsp_ready_i;

    assign rsp_result_o   = rsp_valid_o ? headEntry[EW-1 -: WIDTH] : '0;
    assign rsp_status_o   = rsp_valid_o ? headEntry[TAG_WIDTH +: 5] : '0;
    assign rsp_tag_o      = rsp_valid_o ? headEntry[TAG_WIDTH-1:0] : '0;
    assign fpu_operands_o = issueOps_q;
    assign fpu_tag_o      = issueTag_q;
    assign fpu_flush_o    = flushPulse_q;
    assign credits_o      = credits_q;
    assign idle_o         = (state_q == ST_IDLE);

    always_comb begin
        state_d      = state_q;
        issueValid_d = issueValid_q;
        issueOps_d   = issueOps_q;
        issueTag_d   = issueTag_q;
        credits_d    = credits_q + CW'(issueFire) - CW'(rspPop);
        wrPtr_d      = wrPtr_q + (AW+1)'(rspPush);
        rdPtr_d      = rdPtr_q + (AW+1)'(rspPop);
        flushPulse_d = flushStart;

        if (reqAccept) begin
            issueValid_d = 1'b1;
            issueOps_d   = req_operands_i;
            issueTag_d   = req_tag_i;
        end else if (issueFire) begin
            issueValid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (reqAccept) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if ((credits_q == '0) && !issueValid_q && !reqAccept) state_d = ST_IDLE;
            end
            ST_FLUSH: begin
                if (!fpu_busy_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Flush wins over everything else that happens in the same cycle.
        if (flushStart) begin
            state_d      = ST_FLUSH;
            issueValid_d = 1'b0;
            credits_d    = '0;
            wrPtr_d      = '0;
            rdPtr_d      = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            issueValid_q <= 1'b0;
            issueOps_q   <= '0;
            issueTag_q   <= '0;
            credits_q    <= '0;
            flushPulse_q <= 1'b0;
            started_q    <= 1'b0;
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
        end else begin
            state_q      <= state_d;
            issueValid_q <= issueValid_d;
            issueOps_q   <= issueOps_d;
            issueTag_q   <= issueTag_d;
            credits_q    <= credits_d;
            flushPulse_q <= flushPulse_d;
            started_q    <= 1'b1;
            wrPtr_q      <= wrPtr_d;
            rdPtr_q      <= rdPtr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rspPush) fifoMem_q[wrPtr_q[AW-1:0]] <= {fpu_result_i, fpu_status_i, fpu_tag_i};
    end

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Directed self-checking bench for fp_issue_ctrl: single op, backpressure, stall, reset and flush.
module tb_fp_issue_ctrl;

    logic         clk;
    logic         rstN;
    logic         reqValid;
    logic         reqReady;
    logic [191:0] reqOperands;
    logic [3:0]   reqTag;
    logic         fpuInValid;
    logic         fpuInReady;
    logic [191:0] fpuOperands;
    logic [3:0]   fpuTagOut;
    logic         fpuFlush;
    logic [63:0]  fpuResult;
    logic [4:0]   fpuStatus;
    logic [3:0]   fpuTagIn;
    logic         fpuOutValid;
    logic         fpuOutReady;
    logic         fpuBusy;
    logic         rspValid;
    logic         rspReady;
    logic [63:0]  rspResult;
    logic [4:0]   rspStatus;
    logic [3:0]   rspTag;
    logic         flushReq;
    logic         idle;
    logic [2:0]   credits;

    int checkCount = 0;
    int errorCount = 0;

    int         sendCount;
    logic [3:0] nextTag;
    bit         fpuEnable;
    int         issuedCount;
    logic [3:0] fpuQ[$];
    logic [3:0] gotTags[$];
    logic [63:0] gotRes[$];

    fp_issue_ctrl #(
        .NUM_OPERANDS(3), .WIDTH(64), .TAG_WIDTH(4), .DEPTH(4)
    ) dut (
        .clk_i(clk), .rst_ni(rstN),
        .req_valid_i(reqValid), .req_ready_o(reqReady),
        .req_operands_i(reqOperands), .req_tag_i(reqTag),
        .fpu_in_valid_o(fpuInValid), .fpu_in_ready_i(fpuInReady),
        .fpu_operands_o(fpuOperands), .fpu_tag_o(fpuTagOut),
        .fpu_flush_o(fpuFlush),
        .fpu_result_i(fpuResult), .fpu_status_i(fpuStatus), .fpu_tag_i(fpuTagIn),
        .fpu_out_valid_i(fpuOutValid), .fpu_out_ready_o(fpuOutReady),
        .fpu_busy_i(fpuBusy),
        .rsp_valid_o(rspValid), .rsp_ready_i(rspReady),
        .rsp_result_o(rspResult), .rsp_status_o(rspStatus), .rsp_tag_o(rspTag),
        .flush_i(flushReq), .idle_o(idle), .credits_o(credits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [191:0] got, input logic [191:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request source plus a simple FPU that returns each issued tag one cycle later.
    task automatic applyStimulus(input int n);
        logic acc, fire, pop;
        for (int i = 0; i < n; i++) begin
            reqValid    = (sendCount > 0);
            reqTag      = nextTag;
            reqOperands = {3{64'(nextTag)}};
            if (fpuEnable && fpuQ.size() > 0) begin
                fpuOutValid = 1'b1;
                fpuTagIn    = fpuQ[0];
                fpuResult   = 64'hA000 + 64'(fpuQ[0]);
            end else begin
                fpuOutValid = 1'b0;
            end
            #3;
            acc  = reqValid && reqReady;
            fire = fpuInValid && fpuInReady;
            pop  = rspValid && rspReady;
            if (fpuOutValid) void'(fpuQ.pop_front());
            if (fire) begin
                fpuQ.push_back(fpuTagOut);
                issuedCount++;
            end
            if (pop) begin
                gotTags.push_back(rspTag);
                gotRes.push_back(rspResult);
            end
            if (acc) begin
                sendCount--;
                nextTag++;
            end
            tick();
        end
        reqValid    = 1'b0;
        fpuOutValid = 1'b0;
    endtask

    initial begin
        rstN = 1'b1; reqValid = 0; reqOperands = '0; reqTag = '0;
        fpuInReady = 1; fpuResult = '0; fpuStatus = '0; fpuTagIn = '0;
        fpuOutValid = 0; fpuBusy = 0; rspReady = 1; flushReq = 0;
        sendCount = 0; nextTag = 0; fpuEnable = 0; issuedCount = 0;

        #1 rstN = 1'b0;
        #2;
        checkOutput("reset reqReady", 192'(reqReady), 192'd0);
        checkOutput("reset fpuInValid", 192'(fpuInValid), 192'd0);
        checkOutput("reset rspValid", 192'(rspValid), 192'd0);
        checkOutput("reset fpuFlush", 192'(fpuFlush), 192'd0);
        checkOutput("reset fpuOutReady", 192'(fpuOutReady), 192'd1);
        checkOutput("reset idle", 192'(idle), 192'd1);
        checkOutput("reset credits", 192'(credits), 192'd0);
        #20 rstN = 1'b1;
        tick(); tick();

        // Single operation
        reqValid = 1; reqTag = 4'h3; reqOperands = {3{64'h4008000000000000}};
        #3 checkOutput("single reqReady", 192'(reqReady), 192'd1);
        tick();
        reqValid = 0;
        #3;
        checkOutput("single fpuInValid", 192'(fpuInValid), 192'd1);
        checkOutput("single operands", fpuOperands, {3{64'h4008000000000000}});
        checkOutput("single fpuTag", 192'(fpuTagOut), 192'h3);
        checkOutput("single not idle", 192'(idle), 192'd0);
        tick();
        fpuOutValid = 1; fpuResult = 64'h4018000000000000; fpuTagIn = 4'h3; fpuStatus = 5'b00001;
        #3 checkOutput("single credits1", 192'(credits), 192'd1);
        tick();
        fpuOutValid = 0;
        #3;
        checkOutput("single rspValid", 192'(rspValid), 192'd1);
        checkOutput("single rspResult", 192'(rspResult), 192'h4018000000000000);
        checkOutput("single rspStatus", 192'(rspStatus), 192'h1);
        checkOutput("single rspTag", 192'(rspTag), 192'h3);
        tick(); tick();
        #3;
        checkOutput("single credits0", 192'(credits), 192'd0);
        checkOutput("single idle", 192'(idle), 192'd1);
        checkOutput("single rspValid low", 192'(rspValid), 192'd0);

        // Response backpressure: only DEPTH ops may be outstanding
        tick();
        rspReady = 0; fpuEnable = 0; sendCount = 6; nextTag = 0; issuedCount = 0;
        gotTags.delete(); gotRes.delete(); fpuQ.delete();
        applyStimulus(10);
        reqValid = 1; reqTag = nextTag;
        #3;
        checkOutput("bp issued", 192'(issuedCount), 192'd4);
        checkOutput("bp credits", 192'(credits), 192'd4);
        checkOutput("bp fpuInValid", 192'(fpuInValid), 192'd0);
        checkOutput("bp reqReady", 192'(reqReady), 192'd0);
        tick();
        fpuEnable = 1; rspReady = 1;
        applyStimulus(30);
        checkOutput("bp rsp count", 192'(gotTags.size()), 192'd6);
        for (int i = 0; i < 6 && i < gotTags.size(); i++) begin
            checkOutput($sformatf("bp tag%0d", i), 192'(gotTags[i]), 192'(i));
            checkOutput($sformatf("bp res%0d", i), 192'(gotRes[i]), 192'(64'hA000 + i));
        end
        #3;
        checkOutput("bp credits0", 192'(credits), 192'd0);
        checkOutput("bp idle", 192'(idle), 192'd1);

        // Simultaneous FIFO push and pop with all credits in use
        tick();
        rspReady = 0; fpuEnable = 0; sendCount = 4; nextTag = 0;
        gotTags.delete(); gotRes.delete(); fpuQ.delete();
        applyStimulus(7);
        #3 checkOutput("pp credits4", 192'(credits), 192'd4);
        tick();
        fpuEnable = 1;
        applyStimulus(3);
        #3;
        checkOutput("pp rspValid", 192'(rspValid), 192'd1);
        checkOutput("pp credits hold", 192'(credits), 192'd4);
        tick();
        rspReady = 1;
        applyStimulus(1);
        rspReady = 0;
        #3;
        checkOutput("pp credits3", 192'(credits), 192'd3);
        checkOutput("pp head tag", 192'(rspTag), 192'd1);
        tick();
        rspReady = 1;
        applyStimulus(8);
        checkOutput("pp rsp count", 192'(gotTags.size()), 192'd4);
        for (int i = 0; i < 4 && i < gotTags.size(); i++)
            checkOutput($sformatf("pp tag%0d", i), 192'(gotTags[i]), 192'(i));
        #3 checkOutput("pp idle", 192'(idle), 192'd1);

        // FPU stall holds the issued operands
        tick();
        reqValid = 1; reqTag = 4'h7; reqOperands = {3{64'h1111}};
        tick();
        reqTag = 4'h8; reqOperands = {3{64'h2222}};
        #3 checkOutput("stall ready on fire", 192'(reqReady), 192'd1);
        tick();
        fpuInReady = 0; reqTag = 4'h9; reqOperands = {3{64'h3333}};
        #3;
        checkOutput("stall fpuInValid", 192'(fpuInValid), 192'd1);
        checkOutput("stall reqReady", 192'(reqReady), 192'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            #3;
            checkOutput($sformatf("stall ops%0d", i), fpuOperands, {3{64'h2222}});
            checkOutput($sformatf("stall tag%0d", i), 192'(fpuTagOut), 192'h8);
            checkOutput($sformatf("stall ready%0d", i), 192'(reqReady), 192'd0);
        end
        reqValid = 0; fpuInReady = 1;
        tick();
        rspReady = 0; fpuOutValid = 1; fpuTagIn = 4'h7; fpuResult = 64'h77;
        tick();
        fpuOutValid = 0;
        #3;
        checkOutput("stall rspValid", 192'(rspValid), 192'd1);
        checkOutput("stall credits2", 192'(credits), 192'd2);

        // Asynchronous reset in the middle of traffic
        #1 rstN = 1'b0;
        #1;
        checkOutput("midreset rspValid", 192'(rspValid), 192'd0);
        checkOutput("midreset credits", 192'(credits), 192'd0);
        checkOutput("midreset idle", 192'(idle), 192'd1);
        checkOutput("midreset reqReady", 192'(reqReady), 192'd0);
        checkOutput("midreset fpuOutReady", 192'(fpuOutReady), 192'd1);
        #2 rstN = 1'b1;
        rspReady = 1;
        tick(); tick(); tick();
        #3;
        checkOutput("postreset rspValid", 192'(rspValid), 192'd0);
        checkOutput("postreset idle", 192'(idle), 192'd1);

        // Flush with three ops in flight
        tick();
        fpuEnable = 0; sendCount = 3; nextTag = 0; fpuQ.delete(); gotTags.delete();
        applyStimulus(6);
        #3 checkOutput("flush pre credits", 192'(credits), 192'd3);
        tick();
        flushReq = 1; fpuBusy = 1;
        tick();
        flushReq = 1; fpuOutValid = 1; fpuTagIn = 4'h0; fpuResult = 64'h55;
        #3;
        checkOutput("flush pulse", 192'(fpuFlush), 192'd1);
        checkOutput("flush credits", 192'(credits), 192'd0);
        checkOutput("flush reqReady", 192'(reqReady), 192'd0);
        checkOutput("flush fpuInValid", 192'(fpuInValid), 192'd0);
        checkOutput("flush not idle", 192'(idle), 192'd0);
        tick();
        flushReq = 0; fpuTagIn = 4'h1;
        #3;
        checkOutput("flush no repulse", 192'(fpuFlush), 192'd0);
        checkOutput("flush rspValid", 192'(rspValid), 192'd0);
        tick();
        fpuOutValid = 0;
        #3 checkOutput("flush busy holds", 192'(idle), 192'd0);
        fpuBusy = 0;
        tick();
        #3;
        checkOutput("flush idle", 192'(idle), 192'd1);
        checkOutput("flush dropped", 192'(rspValid), 192'd0);
        checkOutput("flush credits idle", 192'(credits), 192'd0);

        // Normal operation resumes after the flush
        tick();
        fpuQ.delete(); gotTags.delete(); gotRes.delete();
        fpuEnable = 1; rspReady = 1; sendCount = 1; nextTag = 4'hC;
        applyStimulus(8);
        checkOutput("resume count", 192'(gotTags.size()), 192'd1);
        if (gotTags.size() > 0) checkOutput("resume tag", 192'(gotTags[0]), 192'hC);
        #3 checkOutput("resume idle", 192'(idle), 192'd1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
